// File: rtl/grf_wport_arbiter_if.sv
// Purpose: bundle of W-stage writeback, secondary writer and register-file write-port signals.
// Latency: wires only; timing is defined by the arbiter that takes the slave side.
// Backpressure: b_valid/b_ready on the secondary; the primary writer is never back-pressured.
interface grf_wport_arbiter_if;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        grf_we;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata;
  logic [31:0] pending;
  logic        stall_req;

  // Writers and register file view: drive requests, observe port and status.
  modport master (
    output w_we, w_addr, w_data, b_valid, b_addr, b_data,
    input  b_ready, grf_we, grf_waddr, grf_wdata, pending, stall_req
  );

  // Arbiter view.
  modport slave (
    input  w_we, w_addr, w_data, b_valid, b_addr, b_data,
    output b_ready, grf_we, grf_waddr, grf_wdata, pending, stall_req
  );
endinterface

// File: rtl/grf_wport_arbiter.sv
// Purpose: share the single GRF write port between the W-stage writeback and a queued secondary writer.
// Latency: primary 0 cycles; secondary at least 1 cycle from acceptance to grf_we.
// Backpressure: b_ready from registered FIFO occupancy only; stall_req after STARVE_LIMIT blocked cycles.
module grf_wport_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  grf_wport_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

  // FIFO storage; a killed entry still occupies its slot until it reaches the head.
  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [DEPTH-1:0] q_kill;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [3:0]       starve;
  logic [3:0]       starve_nxt;
  logic             stall;

  logic        prim;
  logic        head_vld;
  logic        head_kill;
  logic        head_live;
  logic        pop;
  logic        rdy;
  logic        acc;
  logic        enq;
  logic [31:0] pend;

  // Request decode: register 0 writes are dropped, killed heads drain even under a primary write.
  always_comb begin
    prim      = bus.w_we && (bus.w_addr != 5'd0);
    head_vld  = q_vld[rd_ptr];
    head_kill = q_kill[rd_ptr];
    head_live = head_vld && !head_kill;
    pop       = head_vld && (head_kill || !prim);
    rdy       = reset && (count < DEPTH_C);
    acc       = bus.b_valid && rdy;
    enq       = acc && (bus.b_addr != 5'd0);
  end

  // Write-port mux: primary first, then a live FIFO head, else idle zeros.
  always_comb begin
    bus.grf_we    = 1'b0;
    bus.grf_waddr = 5'd0;
    bus.grf_wdata = 32'd0;
    if (reset) begin
      if (prim) begin
        bus.grf_we    = 1'b1;
        bus.grf_waddr = bus.w_addr;
        bus.grf_wdata = bus.w_data;
      end else if (head_live) begin
        bus.grf_we    = 1'b1;
        bus.grf_waddr = q_addr[rd_ptr];
        bus.grf_wdata = q_data[rd_ptr];
      end
    end
  end

  // Pending mask from registered entry state, so it follows enqueue/pop/kill by one cycle.
  always_comb begin
    pend = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && !q_kill[i]) begin
        pend = pend | (32'd1 << q_addr[i]);
      end
    end
    pend[0] = 1'b0;
  end

  // Starvation count: reset by any head pop or an empty FIFO, saturating otherwise.
  always_comb begin
    starve_nxt = starve;
    if ((count == '0) || pop) begin
      starve_nxt = 4'd0;
    end else if (head_live && prim && (starve != 4'hF)) begin
      starve_nxt = starve + 4'd1;
    end
  end

  // Entry control: kills from a matching primary write, then pop, then the newer enqueue overrides.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_vld  <= '0;
      q_kill <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (prim && q_vld[i] && (q_addr[i] == bus.w_addr)) begin
          q_kill[i] <= 1'b1;
        end
        if (pop && (PW'(i) == rd_ptr)) begin
          q_vld[i]  <= 1'b0;
          q_kill[i] <= 1'b0;
        end
        if (enq && (PW'(i) == wr_ptr)) begin
          q_vld[i]  <= 1'b1;
          q_kill[i] <= 1'b0;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  // Payload storage needs no reset; validity is tracked by q_vld.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wr_ptr] <= bus.b_addr;
      q_data[wr_ptr] <= bus.b_data;
    end
  end

  // Starvation counter and stall request; stall holds until the FIFO has drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= 4'd0;
      stall  <= 1'b0;
    end else begin
      starve <= starve_nxt;
      if (count == '0) begin
        stall <= 1'b0;
      end else if (starve_nxt == LIMIT_C) begin
        stall <= 1'b1;
      end
    end
  end

  assign bus.b_ready   = rdy;
  assign bus.pending   = pend;
  assign bus.stall_req = stall;

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Purpose: directed self-checking bench for grf_wport_arbiter with DEPTH=2, STARVE_LIMIT=4.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench holds b_valid only for offers it expects to be taken, except one full-FIFO probe.
module tb_grf_wport_arbiter;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  grf_wport_arbiter_if bus ();

  grf_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    bus.w_we    = we;
    bus.w_addr  = wa;
    bus.w_data  = wd;
    bus.b_valid = bv;
    bus.b_addr  = ba;
    bus.b_data  = bd;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Watchdog so a broken run still ends with a report.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    drive(0, 0, 0, 1, 5, 32'h1);
    #1;
    chk("rst_b_ready", {31'd0, bus.b_ready}, 32'd0);
    chk("rst_grf_we", {31'd0, bus.grf_we}, 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Secondary alone: one cycle to the port, pending for exactly that cycle.
    drive(0, 0, 0, 1, 5, 32'h1234);
    samp();
    chk("t1_b_ready", {31'd0, bus.b_ready}, 32'd1);
    chk("t1_we_c0", {31'd0, bus.grf_we}, 32'd0);
    chk("t1_pend_c0", bus.pending, 32'd0);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    samp();
    chk("t1_we_c1", {31'd0, bus.grf_we}, 32'd1);
    chk("t1_waddr", {27'd0, bus.grf_waddr}, 32'd5);
    chk("t1_wdata", bus.grf_wdata, 32'h1234);
    chk("t1_pend_c1", bus.pending, 32'h20);
    adv();
    samp();
    chk("t1_we_c2", {31'd0, bus.grf_we}, 32'd0);
    chk("t1_pend_c2", bus.pending, 32'd0);
    adv();

    // Primary hogs the port: FIFO fills, starvation raises stall, then drains in order.
    drive(1, 3, 32'h33, 1, 7, 32'h77);
    samp();
    chk("t2_b_ready_0", {31'd0, bus.b_ready}, 32'd1);
    chk("t2_waddr_0", {27'd0, bus.grf_waddr}, 32'd3);
    adv();
    drive(1, 3, 32'h33, 1, 8, 32'h88);
    samp();
    chk("t2_b_ready_1", {31'd0, bus.b_ready}, 32'd1);
    chk("t2_pend_1", bus.pending, 32'h80);
    adv();
    drive(1, 3, 32'h33, 1, 9, 32'h99);
    samp();
    chk("t2_b_ready_full", {31'd0, bus.b_ready}, 32'd0);
    chk("t2_pend_2", bus.pending, 32'h180);
    chk("t2_stall_2", {31'd0, bus.stall_req}, 32'd0);
    adv();
    drive(1, 3, 32'h33, 0, 0, 0);
    samp();
    chk("t2_stall_3", {31'd0, bus.stall_req}, 32'd0);
    adv();
    samp();
    chk("t2_stall_4", {31'd0, bus.stall_req}, 32'd0);
    adv();
    samp();
    chk("t2_stall_5", {31'd0, bus.stall_req}, 32'd1);
    chk("t2_wdata_5", bus.grf_wdata, 32'h33);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    samp();
    chk("t2_waddr_6", {27'd0, bus.grf_waddr}, 32'd7);
    chk("t2_wdata_6", bus.grf_wdata, 32'h77);
    adv();
    samp();
    chk("t2_waddr_7", {27'd0, bus.grf_waddr}, 32'd8);
    chk("t2_wdata_7", bus.grf_wdata, 32'h88);
    chk("t2_stall_7", {31'd0, bus.stall_req}, 32'd1);
    adv();
    samp();
    chk("t2_we_8", {31'd0, bus.grf_we}, 32'd0);
    chk("t2_stall_8", {31'd0, bus.stall_req}, 32'd1);
    adv();
    samp();
    chk("t2_stall_9", {31'd0, bus.stall_req}, 32'd0);
    adv();

    // Newer primary write kills the queued entry for the same register.
    drive(0, 0, 0, 1, 9, 32'hAAAA);
    samp();
    chk("t3_b_ready", {31'd0, bus.b_ready}, 32'd1);
    adv();
    drive(1, 9, 32'hBBBB, 0, 0, 0);
    samp();
    chk("t3_wdata_p", bus.grf_wdata, 32'hBBBB);
    chk("t3_pend_live", bus.pending, 32'h200);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    samp();
    chk("t3_we_killed", {31'd0, bus.grf_we}, 32'd0);
    chk("t3_pend_killed", bus.pending, 32'd0);
    adv();
    samp();
    chk("t3_we_after", {31'd0, bus.grf_we}, 32'd0);
    chk("t3_b_ready_empty", {31'd0, bus.b_ready}, 32'd1);
    adv();

    // Register 0 on both sides: acknowledged, nothing written or queued.
    drive(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    samp();
    chk("t4_b_ready", {31'd0, bus.b_ready}, 32'd1);
    chk("t4_we_0", {31'd0, bus.grf_we}, 32'd0);
    chk("t4_pend_0", bus.pending, 32'd0);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    samp();
    chk("t4_we_1", {31'd0, bus.grf_we}, 32'd0);
    chk("t4_pend_1", bus.pending, 32'd0);
    adv();

    // Same-cycle primary and secondary to one register: secondary is newer and stays live.
    drive(1, 4, 32'h44, 1, 4, 32'h55);
    samp();
    chk("t5_waddr_p", {27'd0, bus.grf_waddr}, 32'd4);
    chk("t5_wdata_p", bus.grf_wdata, 32'h44);
    chk("t5_b_ready", {31'd0, bus.b_ready}, 32'd1);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    samp();
    chk("t5_we_s", {31'd0, bus.grf_we}, 32'd1);
    chk("t5_wdata_s", bus.grf_wdata, 32'h55);
    chk("t5_pend_s", bus.pending, 32'h10);
    adv();
    samp();
    chk("t5_pend_after", bus.pending, 32'd0);
    adv();

    // Asynchronous reset with a full, stalled FIFO.
    drive(1, 3, 32'h33, 1, 10, 32'hA);
    adv();
    drive(1, 3, 32'h33, 1, 11, 32'hB);
    adv();
    drive(1, 3, 32'h33, 0, 0, 0);
    repeat (3) adv();
    samp();
    chk("t6_stall_pre", {31'd0, bus.stall_req}, 32'd1);
    chk("t6_pend_pre", bus.pending, 32'hC00);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("t6_rst_pend", bus.pending, 32'd0);
    chk("t6_rst_we", {31'd0, bus.grf_we}, 32'd0);
    chk("t6_rst_b_ready", {31'd0, bus.b_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    adv();
    samp();
    chk("t6_post_we", {31'd0, bus.grf_we}, 32'd0);
    chk("t6_post_pend", bus.pending, 32'd0);
    chk("t6_post_b_ready", {31'd0, bus.b_ready}, 32'd1);
    chk("t6_post_stall", {31'd0, bus.stall_req}, 32'd0);
    adv();
    samp();
    chk("t6_post_we2", {31'd0, bus.grf_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/grf_wport_arbiter.md
Name: grf_wport_arbiter

Overview:
- Shares the register file's single write port between two writers:
  - the pipeline W-stage writeback (primary, never back-pressured);
  - a long-latency result source such as the MDU or an uncached load return (secondary, valid/ready).
- Secondary writes are queued in a small FIFO and drain into idle write-port cycles.
- Exports a pending-register mask for the hazard unit, and a stall request if the secondary is starved.
- Sits between the W stage / secondary unit and the register file write inputs.

Parameters:
- DEPTH, 2: secondary FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4: number of consecutive blocked cycles of a non-empty FIFO before stall_req asserts; range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- w_we  in  1  primary write request
- w_addr  in  5  primary destination register
- w_data  in  32  primary write data
- b_valid  in  1  secondary write offered
- b_addr  in  5  secondary destination register
- b_data  in  32  secondary write data
- b_ready  out  1  secondary accepted this cycle when b_valid && b_ready
- grf_we  out  1  register-file write enable
- grf_waddr  out  5  register-file write address
- grf_wdata  out  32  register-file write data
- pending  out  32  bit i = 1 while a live queued write to register i exists; bit 0 is always 0
- stall_req  out  1  request to the hazard unit to freeze the W-stage write

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, all kill flags cleared, starvation counter = 0.
  - stall_req = 0, pending = 0, grf_we = 0, b_ready = 0 while reset is held.
  - Queued entries are lost on a reset mid-operation.
- Primary request: effective request = w_we && w_addr != 0. A write to register 0 is ignored.
- Write-port selection, combinational within the cycle:
  - Primary active: grf_* = w_*, grf_we = 1. Zero latency.
  - Else FIFO head is live: grf_* = head, grf_we = 1, head pops at the clock edge.
  - Else: grf_we = 0, grf_waddr = 0, grf_wdata = 0.
- Killed head entry:
  - Pops in any cycle, including a cycle with a primary write.
  - Never drives grf_we.
  - Counts as a head pop for the starvation counter.
- Secondary acceptance:
  - b_ready = (count < DEPTH), computed from registered count only. No same-cycle pop credit.
  - An accepted transfer with b_addr == 0 is acknowledged and discarded, not enqueued.
  - A secondary write always goes through the FIFO. Minimum latency from acceptance to grf_we is 1 cycle.
  - Enqueue and pop in the same cycle are allowed; count is unchanged.
- Ordering:
  - A primary write to register X kills every queued entry whose address is X (the primary write is newer).
  - A secondary transfer accepted in the same cycle as a primary write to X is enqueued live (it is newer).
  - The FIFO is strictly in order; wrap-around of the read and write pointers is modulo DEPTH.
- pending is the OR over valid, non-killed entries of onehot(addr). It updates the cycle after enqueue, pop or kill.
- Starvation counter (4 bits):
  - Cleared on a head pop or when the FIFO is empty.
  - Otherwise increments each cycle a live head is blocked by a primary write; saturates at 15.
- stall_req:
  - Registered; set at the edge where the counter reaches STARVE_LIMIT.
  - Held until the FIFO is empty, then cleared at the next edge.
  - The pipeline is required to drop w_we while stall_req = 1. If it does not, the primary still wins and no data is lost.
- Full FIFO with b_valid held: b_ready = 0; the secondary holds addr/data stable until accepted.

Test Plan:
- Reset released, b_valid=1, b_addr=5, b_data=0x1234 with no primary: b_ready=1; next cycle grf_we=1, waddr=5, wdata=0x1234; pending[5]=1 for exactly that cycle.
- Primary w_addr=3 every cycle while secondary enqueues 7 then 8 (DEPTH=2): third offer sees b_ready=0. After 4 blocked cycles stall_req=1. Primary drops: writes 7 then 8 appear on consecutive cycles; stall_req clears one cycle after the FIFO is empty.
- Queue entry for register 9 (data 0xAAAA), then primary writes 9 with 0xBBBB: the entry is killed and pending[9]=0 next cycle. The killed entry pops with grf_we=0; register 9 never receives 0xAAAA after 0xBBBB.
- Secondary b_addr=0 and primary w_addr=0: b_ready=1, nothing enqueued, grf_we stays 0, pending stays 0.
- Primary write to 4 and secondary offer to 4 in the same cycle: primary drives the port; the queued entry stays live and writes the next idle cycle.
- Pull reset low with 2 entries queued and stall_req=1: stall_req, pending, grf_we and b_ready go to 0 immediately, without waiting for a clock edge. After release the FIFO is empty.
